kb_arbiter: RTL and testbench

KB_ARBITER -- requirements
Module: kb_arbiter

---
 rtl/kb_arb_pkg.sv | 24 ++
 rtl/kb_arbiter_cell.sv | 25 ++
 rtl/kb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_kb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_arb_pkg.sv
// Shared types and constants for the kb_arbiter block: FSM state encoding,
// command width, default requester count and the kb cell update rule.
package kb_arb_pkg;

  localparam int KB_CMD_W    = 3;
  localparam int KB_NREQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_e;

  // {K,B}: 00 toggle, 01 clear, 10 set, 11 hold.
  function automatic logic kb_next(input logic q, input logic k, input logic b);
    case ({k, b})
      2'b00:   kb_next = ~q;
      2'b01:   kb_next = 1'b0;
      2'b10:   kb_next = 1'b1;
      default: kb_next = q;
    endcase
  endfunction

endpackage

// File: rtl/kb_arbiter_cell.sv
// Single kb storage cell (toggle/clear/set/hold) with asynchronous
// active-low clear.
module kb_cell
  import kb_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic k,
  input  logic b,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= kb_next(q_q, k, b);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/kb_arbiter.sv
// Arbitrates NREQ requesters onto a pair of kb cells and reports the result.
// Round-robin by default; define KB_ARB_FIXED_PRIO_EN for lowest-index-wins.
module kb_arbiter
  import kb_arb_pkg::*;
#(
  parameter int NREQ  = KB_NREQ_DEF,
  parameter int CMD_W = KB_CMD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CMD_W-1:0]   cmd,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [1:0]              rsp_q,
  output logic                    rsp_z
);

  localparam int IDX_W = $clog2(NREQ);

  // gnt and rsp_valid are one-cycle strobes with no back-pressure: a grant
  // is accepted the cycle it is shown, and the response for it is strobed
  // exactly two cycles later; rsp_* hold their value until the next strobe.

  arb_state_e        state_q, state_d;
  logic              grant_en;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [CMD_W-1:0]  cmd_q;
  logic [IDX_W-1:0]  id_q;
  logic [IDX_W-1:0]  rsp_id_q;
  logic [1:0]        rsp_q_q;
  logic              rsp_z_q;
  logic              k0, b0, k1, b1;
  logic              q0, q1;
  logic              q0_nxt, q1_nxt;

`ifndef KB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  ptr_q;
`endif

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef KB_ARB_FIXED_PRIO_EN
      sum = (IDX_W+1)'(i);
`else
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
`endif
      idx = sum[IDX_W-1:0];
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d  = ST_ISSUE;
          grant_en = 1'b1;
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Cells only move on the edge leaving ISSUE; every other cycle they hold.
  always_comb begin
    k0 = 1'b1;
    b0 = 1'b1;
    k1 = 1'b1;
    b1 = 1'b1;
    if (state_q == ST_ISSUE) begin
      k0 = ~(cmd_q[0] | cmd_q[1]) & ~cmd_q[2];
      b0 = cmd_q[1];
      k1 = ~cmd_q[2];
      b1 = (~cmd_q[0] | cmd_q[1]) ^ cmd_q[2];
    end
  end

  assign q0_nxt = kb_next(q0, k0, b0);
  assign q1_nxt = kb_next(q1, k1, b1);

  kb_cell u_cell0 (
    .clk   (clk),
    .rst_n (rst_n),
    .k     (k0),
    .b     (b0),
    .q     (q0)
  );

  kb_cell u_cell1 (
    .clk   (clk),
    .rst_n (rst_n),
    .k     (k1),
    .b     (b1),
    .q     (q1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      rsp_q_q  <= '0;
      rsp_z_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        cmd_q <= cmd[int'(sel_idx)*CMD_W +: CMD_W];
        id_q  <= sel_idx;
      end
      if (state_q == ST_ISSUE) begin
        rsp_id_q <= id_q;
        rsp_q_q  <= {q1_nxt, q0_nxt};
        rsp_z_q  <= ~(q1_nxt ^ q0_nxt);
      end
    end
  end

`ifndef KB_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (grant_en) begin
      ptr_q <= (sel_idx == IDX_W'(NREQ-1)) ? '0 : sel_idx + 1'b1;
    end
  end
`endif

  // The grant is combinational in IDLE, so it is masked while reset is held.
  always_comb begin
    gnt = '0;
    if (grant_en && rst_n) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_CAPTURE);
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_kb_arbiter.sv
// Directed bench for kb_arbiter: expected grants/responses are queued by the
// driver and popped by a monitor when the DUT strobes gnt or rsp_valid.
module tb_kb_arbiter;
  import kb_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [NREQ-1:0]  req   = '0;
  logic [NREQ*3-1:0] cmd  = '0;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             rsp_valid;
  logic [IDX_W-1:0] rsp_id;
  logic [1:0]       rsp_q;
  logic             rsp_z;

  kb_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cmd       (cmd),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_z     (rsp_z)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // scoreboard
  int             n_cmp = 0;
  int             n_err = 0;
  logic [NREQ-1:0] exp_gnt_q[$];
  logic [4:0]      exp_q[$];
  int              gcyc_q[$];
  logic [4:0]      last_rsp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  always @(negedge rst_n) begin
    gcyc_q.delete();
    last_rsp = '0;
  end

  always @(negedge clk) begin
    logic [4:0] act;
    logic [4:0] e;
    int         g;
    if (rst_n) begin
      act = {rsp_id, rsp_q, rsp_z};
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) flag("gnt_unexpected", 32'(gnt));
        else check("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
        gcyc_q.push_back(cyc);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          flag("rsp_unexpected", 32'(act));
        end else begin
          e = exp_q.pop_front();
          check("rsp", 32'(act), 32'(e));
          last_rsp = e;
        end
        if (gcyc_q.size() == 0) flag("rsp_no_grant", 32'(cyc));
        else begin
          g = gcyc_q.pop_front();
          check("rsp_latency", 32'(cyc), 32'(g + 2));
        end
      end else begin
        check("rsp_hold", 32'(act), 32'(last_rsp));
      end
    end
  end

  // driver tasks
  task automatic check_reset(input string name);
    check(name, {gnt, busy, rsp_valid, rsp_id, rsp_q, rsp_z}, 32'd0);
    check({name, "_cells"}, {dut.u_cell1.q, dut.u_cell0.q}, 32'd0);
  endtask

  task automatic wait_gnt(output int gc);
    gc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (gnt != '0) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) flag("gnt_timeout", 32'(cyc));
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && exp_gnt_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) flag("drain_timeout", 32'(exp_q.size()));
  endtask

  task automatic issue(input int id, input logic [2:0] c, input logic [1:0] eq, input logic ez);
    int gc;
    @(posedge clk);
    #2;
    cmd = '1;
    cmd[id*3 +: 3] = c;
    req = '0;
    req[id] = 1'b1;
    exp_gnt_q.push_back(NREQ'(1) << id);
    exp_q.push_back({IDX_W'(id), eq, ez});
    wait_gnt(gc);
    @(posedge clk);
    #2;
    req = '0;
    drain();
  endtask

  // directed vectors: cmd -> {Q1,Q0}, z, applied in order from Q=00
  logic [2:0] seq_cmd [8] = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b111, 3'b011, 3'b101, 3'b110};
  logic [1:0] seq_q   [8] = '{2'b01,  2'b00,  2'b11,  2'b00,  2'b10,  2'b10,  2'b01,  2'b10};
  logic       seq_z   [8] = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};

`ifdef KB_ARB_FIXED_PRIO_EN
  logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
  logic [4:0] rr_rsp [5] = '{{2'd0, 2'b11, 1'b1}, {2'd0, 2'b00, 1'b1}, {2'd0, 2'b11, 1'b1},
                             {2'd0, 2'b00, 1'b1}, {2'd0, 2'b11, 1'b1}};
  logic [1:0] pre_q  = 2'b00;
  logic [3:0] abort_gnt = 4'b0001;
`else
  logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [4:0] rr_rsp [5] = '{{2'd0, 2'b11, 1'b1}, {2'd1, 2'b11, 1'b1}, {2'd2, 2'b10, 1'b0},
                             {2'd3, 2'b11, 1'b1}, {2'd0, 2'b00, 1'b1}};
  logic [1:0] pre_q  = 2'b11;
  logic [3:0] abort_gnt = 4'b0010;
`endif

  initial begin
    int gc;
    int prev;
    int raise;

    #1;
    check_reset("reset_init");
    #10;
    rst_n = 1'b1;

    issue(0, 3'b100, 2'b11, 1'b1);

    // asynchronous reset mid-run with requests pending
    @(posedge clk);
    #2;
    req   = '1;
    rst_n = 1'b0;
    #1;
    check_reset("reset_midrun");
    req = '0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) issue(i % NREQ, seq_cmd[i], seq_q[i], seq_z[i]);

    // all requesters held from reset
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cmd = {3'b001, 3'b010, 3'b000, 3'b100};
    for (int i = 0; i < 5; i++) begin
      exp_gnt_q.push_back(rr_gnt[i]);
      exp_q.push_back(rr_rsp[i]);
    end
    @(posedge clk);
    #2;
    req = '1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(gc);
      if (i > 0) check("grant_spacing", 32'(gc - prev), 32'd3);
      prev = gc;
    end
    @(posedge clk);
    #2;
    req = '0;
    drain();

    // reset while in ISSUE abandons the operation
    issue(0, 3'b100, pre_q, 1'b1);
    @(posedge clk);
    #2;
    cmd = {3'b111, 3'b100, 3'b100, 3'b001};
    req = 4'b0111;
    exp_gnt_q.push_back(abort_gnt);
    wait_gnt(gc);
    @(posedge clk);
    #2;
    check("abort_in_issue", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("reset_issue");
    exp_gnt_q.push_back(4'b0001);
    exp_q.push_back({2'd0, 2'b11, 1'b1});
    #1;
    rst_n = 1'b1;
    wait_gnt(gc);
    @(posedge clk);
    #2;
    req = '0;
    drain();

    // request rising during CAPTURE waits for the following IDLE
    @(posedge clk);
    #2;
    cmd = {3'b111, 3'b111, 3'b111, 3'b010};
    req = 4'b0001;
    exp_gnt_q.push_back(4'b0001);
    exp_q.push_back({2'd0, 2'b10, 1'b0});
    wait_gnt(gc);
    @(posedge clk);
    #2;
    req = '0;
    @(posedge clk);
    #2;
    check("late_in_capture", 32'(rsp_valid), 32'd1);
    req = 4'b0100;
    raise = cyc;
    exp_gnt_q.push_back(4'b0100);
    exp_q.push_back({2'd2, 2'b00, 1'b1});
    wait_gnt(gc);
    check("late_gnt_gap", 32'(gc - raise), 32'd1);
    @(posedge clk);
    #2;
    req = '0;
    drain();

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
